d_mem_responder: RTL and testbench

- Data-memory responder for the 5-stage pipelined CPU's MEM stage: the memory end of the CPU's load/store request interface.
- Accepts one 16-bit word load or store per transaction over a valid/ready handshake.
- Services each transaction after a programmable number of wait states, then returns a single-cycle response.
- The CPU's stall logic holds the pipeline until the response arrives; this replaces the zero-wait data memory.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/d_mem_array.sv | 25 ++
 rtl/d_mem_responder.sv | 121 ++++++++++++
 tb/tb_d_mem_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int DMEM_ADDR_BITS   = 8;
    localparam int DMEM_WAIT_CYCLES = 2;
    localparam int DMEM_DATA_W      = 16;
    localparam int DMEM_CNT_W       = 4;

endpackage

// File: rtl/d_mem_array.sv
// Word storage: synchronous write, registered read, no reset so it maps onto block RAM.
module d_mem_array #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_W    = 16
) (
    input  logic                 Clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_BITS)-1];

    // Read-first: a store's rdata is never consumed, the responder echoes wdata instead.
    always_ff @(posedge Clk) begin
        if (en) begin
            if (we)
                mem[addr] <= wdata;
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/d_mem_responder.sv
// Load/store responder with programmable wait states and a one-cycle response pulse.
module d_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS   = DMEM_ADDR_BITS,
    parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES,
    parameter int DATA_W      = DMEM_DATA_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [15:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy
);

    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [DMEM_CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? DMEM_CNT_W'(WAIT_CYCLES - 1) : '0;

    dmem_state_e           state;
    logic [DMEM_CNT_W-1:0] cnt;
    logic                  write_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [DATA_W-1:0]     wdata_q;

    logic                  accept;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_BITS-1:0]  ram_addr;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     ram_rdata;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_ready && req_valid;

    generate
        if (ADDR_BITS < 16) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[15:ADDR_BITS];
        end
    endgenerate

    // With no wait states the access happens on the accept edge straight from the request
    // inputs; otherwise it uses the latched request on the last WAIT edge.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        if (ZERO_WAIT) begin
            ram_en    = accept;
            ram_we    = accept && req_write;
            ram_addr  = req_addr[ADDR_BITS-1:0];
            ram_wdata = req_wdata;
        end else begin
            ram_en    = (state == WAIT) && (cnt == '0);
            ram_we    = ram_en && write_q;
        end
    end

    d_mem_array #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_W    (DATA_W)
    ) u_array (
        .Clk   (Clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // The RAM output is valid during RESP; the response pulse is registered from there.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= IDLE;
            cnt        <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr[ADDR_BITS-1:0];
                        wdata_q <= req_wdata;
                        if (ZERO_WAIT) begin
                            state <= RESP;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0)
                        state <= RESP;
                    else
                        cnt <= cnt - 1'b1;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b1;
                    resp_rdata <= write_q ? wdata_q : ram_rdata;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_d_mem_responder.sv
// Scoreboard bench for d_mem_responder (WAIT_CYCLES=2 main instance, WAIT_CYCLES=0 side instance).
module tb_d_mem_responder;

    localparam int W = 2;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, busy;
    logic [15:0] resp_rdata;

    logic        r0_valid = 1'b0, r0_write = 1'b0;
    logic [15:0] r0_addr = '0, r0_wdata = '0;
    logic        r0_ready, r0_resp_valid, r0_busy;
    logic [15:0] r0_rdata;

    always #5 Clk = ~Clk;

    d_mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(W), .DATA_W(16)) dut (
        .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy)
    );

    d_mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0), .DATA_W(16)) dut0 (
        .Clk(Clk), .Rst(Rst), .req_valid(r0_valid), .req_write(r0_write),
        .req_addr(r0_addr), .req_wdata(r0_wdata), .req_ready(r0_ready),
        .resp_valid(r0_resp_valid), .resp_rdata(r0_rdata), .busy(r0_busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [15:0] d;
        int          cyc;
    } sb_t;

    sb_t         q[$];
    logic [15:0] model [0:255];
    int          cyc = 0;
    int          bsy_left = 0;
    bit          b2b = 1'b0;
    int          b2b_n = 0;
    int          b2b_last = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: accepts are pushed with their expected response cycle; responses pop and compare.
    always @(negedge Clk) begin
        if (!Rst) begin
            q.delete();
            bsy_left = 0;
            chk("rst_resp_valid", {31'b0, resp_valid}, 0);
        end else begin
            chk("ready", {31'b0, req_ready}, {31'b0, bsy_left == 0});
            chk("busy", {31'b0, busy}, {31'b0, bsy_left != 0});
            if (bsy_left > 0) bsy_left--;
            if (resp_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_resp", {31'b0, resp_valid}, 0);
                end else begin
                    sb_t e;
                    logic [15:0] exp;
                    e = q.pop_front();
                    exp = e.w ? e.d : model[e.a];
                    chk("resp_cyc", cyc, e.cyc);
                    chk("resp_rdata", {16'b0, resp_rdata}, {16'b0, exp});
                    if (e.w) model[e.a] = e.d;
                end
                if (b2b) begin
                    if (b2b_n > 0) chk("b2b_gap", cyc - b2b_last, 4);
                    b2b_last = cyc;
                    b2b_n++;
                end
            end
            if (req_valid && req_ready) begin
                q.push_back('{w: req_write, a: req_addr[7:0], d: req_wdata, cyc: cyc + W + 2});
                bsy_left = W + 1;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d, input bit keep);
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge Clk);
        while (!req_ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", n, 0);
        @(posedge Clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge Clk);
            n++;
        end
        #1;
        chk("drain", q.size(), 0);
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_ready", {31'b0, req_ready}, 1);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_rdata", {16'b0, resp_rdata}, 0);
        chk("rst0_rdata", {16'b0, r0_rdata}, 0);
        @(posedge Clk);
        #1 Rst = 1'b1;

        // Zero-wait instance: response in the cycle after N+1, busy for one cycle.
        for (int k = 0; k < 2; k++) begin
            r0_valid = 1'b1;
            r0_write = (k == 0);
            r0_addr  = 16'h0007;
            r0_wdata = (k == 0) ? 16'h7777 : 16'h0000;
            @(negedge Clk);
            chk("w0_ready", {31'b0, r0_ready}, 1);
            @(posedge Clk);
            #1 r0_valid = 1'b0;
            @(negedge Clk);
            chk("w0_busy", {31'b0, r0_busy}, 1);
            chk("w0_early", {31'b0, r0_resp_valid}, 0);
            @(negedge Clk);
            chk("w0_busy_end", {31'b0, r0_busy}, 0);
            chk("w0_resp", {31'b0, r0_resp_valid}, 1);
            chk("w0_rdata", {16'b0, r0_rdata}, 32'h7777);
            @(negedge Clk);
            chk("w0_pulse", {31'b0, r0_resp_valid}, 0);
            @(posedge Clk);
            #1;
        end

        issue(1'b1, 16'h0010, 16'hBEEF, 0);
        issue(1'b0, 16'h0010, 16'h0000, 0);
        issue(1'b1, 16'h0105, 16'h1234, 0);
        issue(1'b0, 16'h0005, 16'h0000, 0);
        drain();

        b2b = 1'b1;
        issue(1'b0, 16'h0010, 16'h0000, 1);
        issue(1'b0, 16'h0005, 16'h0000, 1);
        issue(1'b0, 16'h0105, 16'h0000, 0);
        drain();
        repeat (2) @(posedge Clk);
        #1;
        b2b = 1'b0;
        chk("b2b_count", b2b_n, 3);

        issue(1'b1, 16'h0020, 16'h00AA, 0);
        req_wdata = 16'h5555;
        req_addr  = 16'h0021;
        issue(1'b0, 16'h0020, 16'h0000, 0);
        drain();

        issue(1'b1, 16'h0030, 16'h1111, 0);
        drain();
        issue(1'b1, 16'h0030, 16'hCAFE, 0);
        Rst = 1'b0;
        @(posedge Clk);
        #1 Rst = 1'b1;
        @(negedge Clk);
        chk("post_rst_ready", {31'b0, req_ready}, 1);
        chk("post_rst_resp", {31'b0, resp_valid}, 0);
        @(posedge Clk);
        #1;
        issue(1'b0, 16'h0030, 16'h0000, 0);
        drain();
        repeat (3) @(posedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
